// File: rtl/pixel_stream_framer_pkg.sv
// pixel_stream_pkg: shared defaults and skid buffer state encoding for the pixel framer.
package pixel_stream_pkg;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_LINE_PIXELS = 512;
  localparam int DEF_FRAME_LINES = 512;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} skid_state_t;
endpackage

// File: rtl/pixel_stream_framer_if.sv
// pixel_stream_framer_if: upstream/downstream pixel handshake bundle.
interface pixel_stream_framer_if #(parameter int DATA_WIDTH = pixel_stream_pkg::DEF_DATA_WIDTH);
  logic i_data_valid;
  logic [DATA_WIDTH-1:0] i_data;
  logic o_data_ready;
  logic o_data_valid;
  logic [DATA_WIDTH-1:0] o_data;
  logic o_data_user;
  logic o_data_last;
  logic i_data_ready;
  modport slave (input i_data_valid, i_data, i_data_ready,
                 output o_data_ready, o_data_valid, o_data, o_data_user, o_data_last);
  modport master (output i_data_valid, i_data, i_data_ready,
                  input o_data_ready, o_data_valid, o_data, o_data_user, o_data_last);
endinterface

// File: rtl/pixel_stream_framer_skid.sv
// axis_skid_buffer: 2-entry skid buffer with registered ready; out_data is the head entry.
module axis_skid_buffer
  import pixel_stream_pkg::*;
#(parameter int W = 10) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready
);
  skid_state_t state, state_n;
  logic [W-1:0] skid;
  logic push, pop;
  assign push = in_valid & in_ready & ~clear;
  assign pop = out_valid & out_ready & ~clear;
  assign out_valid = state != EMPTY;
  always_comb begin
    state_n = clear ? EMPTY :
              (state == EMPTY) ? (push ? ONE : EMPTY) :
              (state == ONE) ? ((push && !pop) ? FULL : (!push && pop) ? EMPTY : ONE) :
              (pop ? ONE : FULL);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      in_ready <= 1'b0;
      out_data <= '0;
      skid <= '0;
    end else begin
      state <= state_n;
      in_ready <= state_n != FULL;
      if (push && (state == EMPTY || pop)) out_data <= in_data;
      else if (pop && state == FULL) out_data <= skid;
      if (push && !pop && state == ONE) skid <= in_data;
    end
  end
endmodule

// File: rtl/pixel_stream_framer.sv
// pixel_stream_framer: tags pixels with start-of-frame/end-of-line and counts completed frames.
module pixel_stream_framer
  import pixel_stream_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LINE_PIXELS = DEF_LINE_PIXELS,
  parameter int FRAME_LINES = DEF_FRAME_LINES
) (
  input  logic        axi_clk,
  input  logic        axi_reset_n,
  input  logic        i_soft_clear,
  pixel_stream_framer_if.slave s,
  output logic        o_frame_done,
  output logic [15:0] o_frame_count
);
  localparam int CW = $clog2(LINE_PIXELS);
  localparam int RW = $clog2(FRAME_LINES);
  localparam int W = DATA_WIDTH + 2;
  logic [CW-1:0] col;
  logic [RW-1:0] row, out_row;
  logic push, pop, col_last, row_last, out_row_last, frame_end;
  logic [W-1:0] out_w;
  assign push = s.i_data_valid & s.o_data_ready & ~i_soft_clear;
  assign pop = s.o_data_valid & s.i_data_ready & ~i_soft_clear;
  assign col_last = col == CW'(LINE_PIXELS - 1);
  assign row_last = row == RW'(FRAME_LINES - 1);
  // Output-side line counter follows transfers so frame end needs no extra buffered tag.
  assign out_row_last = out_row == RW'(FRAME_LINES - 1);
  assign frame_end = pop & s.o_data_last & out_row_last;
  assign {s.o_data_user, s.o_data_last, s.o_data} = out_w;
  axis_skid_buffer #(.W(W)) u_skid (
    .clk(axi_clk),
    .rst_n(axi_reset_n),
    .clear(i_soft_clear),
    .in_valid(s.i_data_valid),
    .in_data({col == '0 && row == '0, col_last, s.i_data}),
    .in_ready(s.o_data_ready),
    .out_valid(s.o_data_valid),
    .out_data(out_w),
    .out_ready(s.i_data_ready)
  );
  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      col <= '0;
      row <= '0;
      out_row <= '0;
      o_frame_done <= 1'b0;
      o_frame_count <= '0;
    end else if (i_soft_clear) begin
      col <= '0;
      row <= '0;
      out_row <= '0;
      o_frame_done <= 1'b0;
    end else begin
      o_frame_done <= frame_end;
      o_frame_count <= o_frame_count + 16'(frame_end);
      if (push) col <= col_last ? '0 : col + 1'b1;
      if (push && col_last) row <= row_last ? '0 : row + 1'b1;
      if (pop && s.o_data_last) out_row <= out_row_last ? '0 : out_row + 1'b1;
    end
  end
endmodule

// File: tb/tb_pixel_stream_framer.sv
// tb_pixel_stream_framer: directed scenarios with a tag-aware scoreboard for pixel_stream_framer.
module tb_pixel_stream_framer;
  localparam int LP = 4;
  localparam int FL = 3;
  typedef struct {logic [7:0] d; logic u; logic l; logic e;} exp_t;
  logic axi_clk = 1'b0;
  logic axi_reset_n = 1'b1;
  logic i_soft_clear = 1'b0;
  logic o_frame_done;
  logic [15:0] o_frame_count;
  int checks = 0;
  int errors = 0;
  exp_t q[$];
  int mcol = 0;
  int mrow = 0;
  logic [15:0] exp_fc = '0;
  logic exp_done = 1'b0;
  pixel_stream_framer_if #(.DATA_WIDTH(8)) bus();
  pixel_stream_framer #(.DATA_WIDTH(8), .LINE_PIXELS(LP), .FRAME_LINES(FL)) dut (
    .axi_clk(axi_clk),
    .axi_reset_n(axi_reset_n),
    .i_soft_clear(i_soft_clear),
    .s(bus.slave),
    .o_frame_done(o_frame_done),
    .o_frame_count(o_frame_count)
  );
  always #5 axi_clk = ~axi_clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // Called at posedge+1: drive, evaluate at the falling edge, advance to next posedge+1.
  task automatic step(input logic v, input logic [7:0] d, input logic r, input logic clr, output logic acc);
    exp_t e;
    logic xfer;
    logic nd;
    bus.i_data_valid = v;
    bus.i_data = d;
    bus.i_data_ready = r;
    i_soft_clear = clr;
    #4;
    chk("frame_done", {31'b0, o_frame_done}, {31'b0, exp_done});
    chk("frame_count", {16'b0, o_frame_count}, {16'b0, exp_fc});
    chk("out_valid", {31'b0, bus.o_data_valid}, {31'b0, q.size() != 0});
    chk("in_ready", {31'b0, bus.o_data_ready}, {31'b0, q.size() < 2});
    if (bus.o_data_valid && q.size() != 0)
      chk("head", {21'b0, bus.o_data_user, bus.o_data_last, 1'b0, bus.o_data},
          {21'b0, q[0].u, q[0].l, 1'b0, q[0].d});
    acc = v && bus.o_data_ready && !clr;
    xfer = bus.o_data_valid && r && !clr;
    nd = 1'b0;
    if (clr) begin
      q.delete();
      mcol = 0;
      mrow = 0;
    end else begin
      if (xfer && q.size() != 0) begin
        e = q.pop_front();
        if (e.e) begin
          nd = 1'b1;
          exp_fc = exp_fc + 16'd1;
        end
      end
      if (acc) begin
        e.d = d;
        e.u = mcol == 0 && mrow == 0;
        e.l = mcol == LP - 1;
        e.e = e.l && mrow == FL - 1;
        q.push_back(e);
        if (mcol == LP - 1) begin
          mcol = 0;
          mrow = (mrow == FL - 1) ? 0 : mrow + 1;
        end else mcol++;
      end
    end
    exp_done = nd;
    @(posedge axi_clk);
    #1;
  endtask
  task automatic drain();
    logic a;
    for (int i = 0; i < 8 && q.size() != 0; i++) step(1'b0, 8'h00, 1'b1, 1'b0, a);
    chk("drained", q.size(), 0);
    step(1'b0, 8'h00, 1'b1, 1'b0, a);
  endtask
  initial begin
    logic a;
    int sent;
    logic [15:0] base;
    bus.i_data_valid = 1'b0;
    bus.i_data = '0;
    bus.i_data_ready = 1'b0;
    #1 axi_reset_n = 1'b0;
    #2;
    chk("rst_valid", {31'b0, bus.o_data_valid}, 0);
    chk("rst_ready", {31'b0, bus.o_data_ready}, 0);
    chk("rst_count", {16'b0, o_frame_count}, 0);
    #9 axi_reset_n = 1'b1;
    @(posedge axi_clk);
    #1;
    chk("ready_after_rst", {31'b0, bus.o_data_ready}, 1);
    // back-to-back full frame
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 8'(i), 1'b1, 1'b0, a);
      chk("s1_accept", {31'b0, a}, 1);
    end
    drain();
    chk("s1_count", {16'b0, o_frame_count}, 1);
    // stalled downstream: two accepted, third waits
    for (int i = 0; i < 3; i++) step(1'b1, 8'(i), 1'b0, 1'b0, a);
    chk("s2_ready_low", {31'b0, bus.o_data_ready}, 0);
    chk("s2_hold", {24'b0, bus.o_data}, 0);
    step(1'b1, 8'd2, 1'b1, 1'b0, a);
    while (!a && q.size() < 3) step(1'b1, 8'd2, 1'b1, 1'b0, a);
    drain();
    step(1'b0, 8'h00, 1'b1, 1'b1, a);
    // random handshakes over five frames
    base = exp_fc;
    sent = 0;
    for (int c = 0; c < 2000 && sent < 60; c++) begin
      step(1'($urandom_range(0, 1)), 8'(sent), 1'($urandom_range(0, 1)), 1'b0, a);
      if (a) sent++;
    end
    chk("s3_sent", sent, 60);
    drain();
    chk("s3_count", {16'b0, o_frame_count}, {16'b0, base + 16'd5});
    // soft clear with the buffer full
    for (int i = 0; i < 6; i++) step(1'b1, 8'(i), 1'b1, 1'b0, a);
    step(1'b1, 8'd6, 1'b0, 1'b0, a);
    chk("s4_full", q.size(), 2);
    base = exp_fc;
    step(1'b1, 8'd7, 1'b0, 1'b1, a);
    chk("s4_valid_clr", {31'b0, bus.o_data_valid}, 0);
    step(1'b1, 8'd100, 1'b1, 1'b0, a);
    chk("s4_user", {31'b0, bus.o_data_user}, 1);
    drain();
    chk("s4_count", {16'b0, o_frame_count}, {16'b0, base});
    step(1'b0, 8'h00, 1'b1, 1'b1, a);
    // frame counter wrap
    force dut.o_frame_count = 16'hFFFF;
    #1 release dut.o_frame_count;
    exp_fc = 16'hFFFF;
    #1;
    @(posedge axi_clk);
    #1;
    for (int i = 0; i < 12; i++) step(1'b1, 8'(i + 20), 1'b1, 1'b0, a);
    chk("s5_pending_done", {31'b0, exp_done}, 0);
    step(1'b0, 8'h00, 1'b1, 1'b0, a);
    chk("s5_done_seen", {31'b0, exp_done}, 1);
    step(1'b0, 8'h00, 1'b1, 1'b0, a);
    chk("s5_wrap", {16'b0, o_frame_count}, 0);
    // short async reset pulse mid-frame
    step(1'b1, 8'hA5, 1'b1, 1'b0, a);
    step(1'b1, 8'h5A, 1'b0, 1'b0, a);
    step(1'b1, 8'h3C, 1'b0, 1'b0, a);
    bus.i_data_valid = 1'b0;
    #2 axi_reset_n = 1'b0;
    #1;
    chk("ar_valid", {31'b0, bus.o_data_valid}, 0);
    chk("ar_ready", {31'b0, bus.o_data_ready}, 0);
    chk("ar_data", {21'b0, bus.o_data_user, bus.o_data_last, 1'b0, bus.o_data}, 0);
    chk("ar_done", {31'b0, o_frame_done}, 0);
    chk("ar_count", {16'b0, o_frame_count}, 0);
    #2 axi_reset_n = 1'b1;
    q.delete();
    mcol = 0;
    mrow = 0;
    exp_fc = '0;
    exp_done = 1'b0;
    @(posedge axi_clk);
    #1;
    chk("ar_ready_rise", {31'b0, bus.o_data_ready}, 1);
    step(1'b1, 8'h33, 1'b1, 1'b0, a);
    chk("ar_user", {31'b0, bus.o_data_user}, 1);
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
